// File: rtl/alu.sv
// 64-bit Y86 execute-stage ALU: add/sub/and/xor with a registered result and signed-overflow flag.
// Define ALU_FLAGS_EN to add the registered zero (zf) and sign (sf) flag outputs.
module alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic [1:0]  sel,
   output logic [63:0] ans,
   output logic        overflow
`ifdef ALU_FLAGS_EN
   ,
   output logic        zf,
   output logic        sf
`endif
);

   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_AND = 2'b10;
   localparam logic [1:0] SEL_XOR = 2'b11;

   logic        sub;
   logic [63:0] b_eff;
   logic [63:0] sum;
   logic        arith_ovf;
   logic [63:0] result;
   logic        result_ovf;

   // Add and subtract share one carry chain: a + ~b + 1 for subtract.
   assign sub       = (sel == SEL_SUB);
   assign b_eff     = b ^ {64{sub}};
   assign sum       = a + b_eff + {63'd0, sub};
   assign arith_ovf = (a[63] == b_eff[63]) && (sum[63] != a[63]);

   always_comb begin
      result     = sum;
      result_ovf = 1'b0;
      case (sel)
         SEL_ADD,
         SEL_SUB: begin
            result     = sum;
            result_ovf = arith_ovf;
         end
         SEL_AND: result = a & b;
         SEL_XOR: result = a ^ b;
         default: result = sum;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ans      <= 64'd0;
         overflow <= 1'b0;
      end else begin
         ans      <= result;
         overflow <= result_ovf;
      end
   end

`ifdef ALU_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         zf <= 1'b1;
         sf <= 1'b0;
      end else begin
         zf <= (result == 64'd0);
         sf <= result[63];
      end
   end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan vectors plus randomized ops against a 65-bit arithmetic model.
module tb_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] a;
   logic [63:0] b;
   logic [1:0]  sel;
   logic [63:0] ans;
   logic        overflow;
`ifdef ALU_FLAGS_EN
   logic        zf;
   logic        sf;
`endif

   int n_vec = 0;
   int n_err = 0;

   alu dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .sel      (sel),
      .ans      (ans),
      .overflow (overflow)
`ifdef ALU_FLAGS_EN
      ,
      .zf       (zf),
      .sf       (sf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: signed overflow means the exact 65-bit signed result does not fit in 64 bits.
   task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic [1:0] ms,
                        output logic [63:0] r, output logic o);
      logic signed [64:0] wide;
      o = 1'b0;
      case (ms)
         2'b00: begin
            wide = $signed({ma[63], ma}) + $signed({mb[63], mb});
            r    = wide[63:0];
            o    = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
         end
         2'b01: begin
            wide = $signed({ma[63], ma}) - $signed({mb[63], mb});
            r    = wide[63:0];
            o    = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
         end
         2'b10:   r = ma & mb;
         default: r = ma ^ mb;
      endcase
   endtask

   task automatic drive_and_wait(input logic r_in, input logic [63:0] ta, input logic [63:0] tb_v,
                                 input logic [1:0] ts);
      @(negedge clk);
      rst = r_in;
      a   = ta;
      b   = tb_v;
      sel = ts;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input logic [63:0] e_ans, input logic e_ovf);
      check({tag, ".ans"}, ans, e_ans);
      check({tag, ".ovf"}, {63'd0, overflow}, {63'd0, e_ovf});
`ifdef ALU_FLAGS_EN
      check({tag, ".zf"}, {63'd0, zf}, {63'd0, (e_ans == 64'd0)});
      check({tag, ".sf"}, {63'd0, sf}, {63'd0, e_ans[63]});
`endif
   endtask

   task automatic dir_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic [1:0] ts, input logic [63:0] e_ans, input logic e_ovf);
      drive_and_wait(1'b0, ta, tb_v, ts);
      check_outputs(tag, e_ans, e_ovf);
   endtask

   logic [63:0] corner [6];

   initial begin
      logic [63:0] ra, rb, m_ans;
      logic [1:0]  rs;
      logic        m_ovf, do_rst;

      corner[0] = 64'h0;
      corner[1] = 64'h1;
      corner[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      corner[3] = 64'h7FFF_FFFF_FFFF_FFFF;
      corner[4] = 64'h8000_0000_0000_0000;
      corner[5] = 64'h8000_0000_0000_0001;

      rst = 1'b1; a = 64'd5; b = 64'd7; sel = 2'b00;

      drive_and_wait(1'b1, 64'd5, 64'd7, 2'b00);
      check_outputs("rst0", 64'd0, 1'b0);
      drive_and_wait(1'b1, 64'd5, 64'd7, 2'b00);
      check_outputs("rst1", 64'd0, 1'b0);
      dir_op("rst_rel", 64'd5, 64'd7, 2'b00, 64'd12, 1'b0);

      dir_op("add0", 64'h13, 64'hA, 2'b00, 64'h1D, 1'b0);
      dir_op("add1", 64'h1E0_0F87, 64'h4047, 2'b00, 64'h1E0_4FCE, 1'b0);
      dir_op("sub0", 64'h153CAE, 64'h55F5, 2'b01, 64'h14E6B9, 1'b0);
      dir_op("sub1", 64'h0, 64'h1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      dir_op("and0", 64'h7841, 64'h1C57, 2'b10, 64'h1841, 1'b0);
      dir_op("xor0", 64'h7841, 64'h1C57, 2'b11, 64'h6416, 1'b0);
      dir_op("xor1", 64'hF571_F1FF_81E0_70D1, 64'hFFFF_FBC0_003A_2DF8, 2'b11,
             64'h0A8E_0A3F_81DA_5D29, 1'b0);
      dir_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 64'h8000_0000_0000_0000, 1'b1);
      dir_op("ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      dir_op("ovf_neg", 64'h0, 64'h8000_0000_0000_0000, 2'b01, 64'h8000_0000_0000_0000, 1'b1);
      dir_op("ovf_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 64'h0, 1'b1);
      dir_op("carry_no_ovf", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 64'h0, 1'b0);

      // Back-to-back sel changes with fixed operands.
      dir_op("pipe0", 64'h7841, 64'h1C57, 2'b00, 64'h9498, 1'b0);
      dir_op("pipe1", 64'h7841, 64'h1C57, 2'b01, 64'h5BEA, 1'b0);
      dir_op("pipe2", 64'h7841, 64'h1C57, 2'b10, 64'h1841, 1'b0);
      dir_op("pipe3", 64'h7841, 64'h1C57, 2'b11, 64'h6416, 1'b0);

      // Mid-stream reset discards the op captured on that edge.
      drive_and_wait(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00);
      check_outputs("rst_mid", 64'd0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) ra = corner[$urandom_range(0, 5)];
         if ($urandom_range(0, 3) == 0) rb = corner[$urandom_range(0, 5)];
         rs     = 2'($urandom_range(0, 3));
         do_rst = ($urandom_range(0, 19) == 0);
         model(ra, rb, rs, m_ans, m_ovf);
         drive_and_wait(do_rst, ra, rb, rs);
         if (do_rst)
            check_outputs("rand_rst", 64'd0, 1'b0);
         else
            check_outputs("rand", m_ans, m_ovf);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

64-bit integer arithmetic/logic unit for the Y86 execute stage. Takes two signed 64-bit operands and a 2-bit function select. Produces a registered result plus a signed-overflow flag one clock later. Optional zero/sign flag outputs feed the condition-code logic.

## Interface

Parameters
- none; the datapath width is fixed at 64 bits.

Ports
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  64  operand A, signed two's complement.
- b  input  64  operand B, signed two's complement.
- sel  input  2  function select: 00 add, 01 sub, 10 and, 11 xor.
- ans  output  64  registered result, signed.
- overflow  output  1  registered signed-overflow flag.
- zf  output  1  registered zero flag. Present only with ALU_FLAGS_EN.
- sf  output  1  registered sign flag. Present only with ALU_FLAGS_EN.

## Operation

- sel=00, add:
  - r = a + b, modulo 2^64, carry-out discarded.
  - ovf = (a[63] == b[63]) && (r[63] != a[63]).
- sel=01, subtract:
  - r = a − b, modulo 2^64.
  - ovf = (a[63] != b[63]) && (r[63] != a[63]).
- sel=10, AND: r = a & b; ovf = 0.
- sel=11, XOR: r = a ^ b; ovf = 0.
- All four sel codes are defined; there is no illegal encoding.
- Single adder/subtractor, built as a + (b ^ {64{sub}}) + sub, so both arithmetic ops share one carry chain.
- Flags (with ALU_FLAGS_EN):
  - zf = (r == 0).
  - sf = r[63].
  - Both flags are computed for every op, including logic ops.
- There is no enable and no handshake. Every rising edge captures the current a, b and sel.

## Timing

- Latency: 1 cycle. Inputs present before edge N appear on ans, overflow, zf and sf after edge N.
- Throughput: one operation per cycle. Back-to-back changes of sel or operands are fully independent.
- The combinational path from a/b/sel to the register inputs must settle within one clock period. There is no combinational path from inputs to outputs.
- Reset:
  - While rst=1 at a rising edge: ans=0, overflow=0, zf=1, sf=0.
  - Inputs are ignored on that edge.
  - Deasserting rst lets the next edge capture normally.
  - Asserting rst mid-stream discards the operation being captured on that edge.
- Before the first reset, output values are undefined.
- Boundary conditions:
  - Add of 0x7FFF_FFFF_FFFF_FFFF + 1 wraps to 0x8000_0000_0000_0000 with overflow=1.
  - Subtract of 0x8000_0000_0000_0000 − 1 wraps to 0x7FFF_FFFF_FFFF_FFFF with overflow=1.
  - 0 − 0x8000_0000_0000_0000 = 0x8000_0000_0000_0000 with overflow=1.
  - Unsigned carry/borrow is not reported.

## Configuration

- ALU_FLAGS_EN defined:
  - zf and sf ports exist.
  - They are registered alongside ans with the reset values above.
- ALU_FLAGS_EN undefined:
  - zf and sf ports and their registers are absent.
  - ans and overflow behave identically in both builds.

## Test plan

- Reset: hold rst=1 for 2 cycles with a=5, b=7, sel=00 → ans=0, overflow=0 (zf=1, sf=0 when ALU_FLAGS_EN is defined). Release rst → next edge gives ans=12.
- Add:
  - a=0x13, b=0xA, sel=00 → ans=0x1D, overflow=0.
  - a=0x1E0_0F87, b=0x4047, sel=00 → ans=0x1E0_4FCE, overflow=0.
- Subtract: a=0x153CAE, b=0x55F5, sel=01 → ans=0x14E6B9, overflow=0. Also a=0x0, b=0x1, sel=01 → ans=0xFFFF_FFFF_FFFF_FFFF, overflow=0 (sf=1).
- Logic ops:
  - a=0x7841, b=0x1C57, sel=10 → ans=0x1841.
  - Same operands, sel=11 → ans=0x6416.
  - a=0xF571_F1FF_81E0_70D1, b=0xFFFF_FBC0_003A_2DF8, sel=11 → ans=0x0A8E_0A3F_81DA_5D29.
  - overflow=0 in all cases.
- Overflow:
  - a=0x7FFF_FFFF_FFFF_FFFF, b=1, sel=00 → ans=0x8000_0000_0000_0000, overflow=1.
  - a=0x8000_0000_0000_0000, b=1, sel=01 → ans=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
  - a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000, sel=00 → ans=0, overflow=1 (zf=1).
- Pipelining: change sel every cycle across 00/01/10/11 with fixed a=0x7841, b=0x1C57 → outputs each lag one cycle: 0x9498, 0x5BEA, 0x1841, 0x6416.
